// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : shared types for the ALU command sequencer
// Rev 1.0
// ============================================================================
package alu_ctrl_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_NOT1 = 3'b110,
    OP_NOT2 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// alu_cmd_sequencer : issues one command at a time to an external ALU and
// returns the new accumulator value through a valid/ready response port.
// Rev 1.0
// ============================================================================
module alu_cmd_sequencer
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_use_acc,
  input  logic              cmd_clr,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_sel,
  output logic              alu_e1,
  output logic              alu_e2_bar,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic [7:0]        op_count
);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  alu_op_e           r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_acc;
  logic [7:0]        r_count;

  logic w_accept;
  logic w_issue;
  logic w_done;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  // Drive is also gated by rst_n so the ALU is never enabled while reset is held.
  assign w_issue  = (r_state == ST_ISSUE) && rst_n;
  assign w_done   = (r_state == ST_RESP) && rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_state_nxt = cmd_clr ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op <= alu_op_e'(cmd_op);
        r_a  <= cmd_use_acc ? r_acc : cmd_a;
        r_b  <= cmd_b;
        if (cmd_clr) r_acc <= '0;
      end
      if (r_state == ST_ISSUE) r_acc <= alu_out;
      if (w_done) r_count <= r_count + 8'd1;
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign alu_in1    = w_issue ? r_a : '0;
  assign alu_in2    = w_issue ? r_b : '0;
  assign alu_sel    = w_issue ? r_op : 3'b000;
  assign alu_e1     = !w_issue;
  assign alu_e2_bar = w_issue;
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_data   = r_acc;
  assign rsp_zero   = (r_acc == '0);
  assign op_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_sequencer : directed bench with a behavioural team ALU model
// Rev 1.0
// ============================================================================
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_use_acc;
  logic       cmd_clr;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [2:0] alu_sel;
  logic       alu_e1;
  logic       alu_e2_bar;
  logic [3:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_zero;
  logic [7:0] op_count;

  int         err_cnt = 0;
  int         chk_cnt = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  alu_cmd_sequencer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_use_acc(cmd_use_acc),
    .cmd_clr    (cmd_clr),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_sel    (alu_sel),
    .alu_e1     (alu_e1),
    .alu_e2_bar (alu_e2_bar),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  // Team ALU: output forced to 0 when e1=1 and e2_bar=0.
  logic [7:0] w_prod;
  assign w_prod = alu_in1 * alu_in2;
  always_comb begin
    alu_out = 4'h0;
    if (!(alu_e1 && !alu_e2_bar)) begin
      case (alu_sel)
        3'b000:  alu_out = alu_in1 + alu_in2;
        3'b001:  alu_out = alu_in1 - alu_in2;
        3'b010:  alu_out = w_prod[3:0];
        3'b011:  alu_out = alu_in1 & alu_in2;
        3'b100:  alu_out = alu_in1 | alu_in2;
        3'b101:  alu_out = alu_in1 ^ alu_in2;
        3'b110:  alu_out = (alu_in1 == 4'h0) ? 4'h1 : 4'h0;
        default: alu_out = (alu_in2 == 4'h0) ? 4'h1 : 4'h0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic send_cmd(input logic [2:0] op, input logic use_acc, input logic clr,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_data, input int stall);
    chk("cmd_ready_idle", {7'd0, cmd_ready}, 8'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_use_acc = use_acc;
    cmd_clr     = clr;
    cmd_a       = a;
    cmd_b       = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (clr) begin
      chk("clr_alu_e1", {7'd0, alu_e1}, 8'd1);
    end else begin
      chk("issue_rsp_valid", {7'd0, rsp_valid}, 8'd0);
      chk("issue_e1", {7'd0, alu_e1}, 8'd0);
      chk("issue_e2_bar", {7'd0, alu_e2_bar}, 8'd1);
      chk("issue_sel", {5'd0, alu_sel}, {5'd0, op});
      if (!use_acc) chk("issue_in1", {4'd0, alu_in1}, {4'd0, a});
      chk("issue_in2", {4'd0, alu_in2}, {4'd0, b});
      @(negedge clk);
    end
    chk("rsp_valid", {7'd0, rsp_valid}, 8'd1);
    chk("rsp_data", {4'd0, rsp_data}, {4'd0, exp_data});
    chk("rsp_zero", {7'd0, rsp_zero}, {7'd0, (exp_data == 4'h0)});
    chk("rsp_cmd_ready", {7'd0, cmd_ready}, 8'd0);
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'b000;
      cmd_clr   = 1'b1;
      @(negedge clk);
      chk("stall_valid", {7'd0, rsp_valid}, 8'd1);
      chk("stall_data", {4'd0, rsp_data}, {4'd0, exp_data});
      chk("stall_cmd_ready", {7'd0, cmd_ready}, 8'd0);
      chk("stall_count", op_count, exp_cnt);
    end
    cmd_valid = 1'b0;
    cmd_clr   = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
    chk("done_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("done_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("done_count", op_count, exp_cnt);
    if (stall > 0) begin
      @(negedge clk);
      chk("no_dup_cmd", {7'd0, cmd_ready}, 8'd1);
      chk("no_dup_count", op_count, exp_cnt);
    end
  endtask

  task automatic quick_clr();
    cmd_valid = 1'b1;
    cmd_clr   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_clr   = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_use_acc = 1'b0;
    cmd_clr = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_e1", {7'd0, alu_e1}, 8'd1);
    chk("rst_e2_bar", {7'd0, alu_e2_bar}, 8'd0);
    chk("rst_ops", {alu_in1, alu_in2}, 8'h00);
    chk("rst_sel", {5'd0, alu_sel}, 8'd0);
    chk("rst_count", op_count, 8'd0);
    chk("rst_acc", {4'd0, rsp_data}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_cmd(3'b000, 1'b0, 1'b0, 4'h5, 4'h0, 4'h5, 0);  // ADD 5+0
    send_cmd(3'b001, 1'b1, 1'b0, 4'h0, 4'h3, 4'h2, 0);  // acc-3
    send_cmd(3'b001, 1'b1, 1'b0, 4'h0, 4'h3, 4'hF, 0);  // wrap below 0
    send_cmd(3'b010, 1'b0, 1'b0, 4'h4, 4'h5, 4'h4, 0);  // 20 -> low nibble
    send_cmd(3'b110, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, 0);  // NOT1 of 2
    send_cmd(3'b110, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 0);  // NOT1 of 0
    send_cmd(3'b111, 1'b0, 1'b0, 4'h0, 4'h6, 4'h0, 0);  // NOT2 of 6
    send_cmd(3'b101, 1'b0, 1'b0, 4'hA, 4'h6, 4'hC, 0);  // XOR
    send_cmd(3'b011, 1'b0, 1'b0, 4'hC, 4'hA, 4'h8, 0);  // AND
    send_cmd(3'b100, 1'b1, 1'b0, 4'h0, 4'h3, 4'hB, 0);  // acc(8) | 3
    send_cmd(3'b000, 1'b0, 1'b0, 4'h9, 4'h8, 4'h1, 0);  // carry dropped
    send_cmd(3'b000, 1'b0, 1'b0, 4'h3, 4'h4, 4'h7, 5);  // backpressure
    send_cmd(3'b000, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 0);  // clear from acc=7
    send_cmd(3'b000, 1'b1, 1'b0, 4'h0, 4'h2, 4'h2, 0);  // acc really cleared

    while (exp_cnt != 8'd0) quick_clr();
    chk("count_wrap", op_count, 8'd0);

    send_cmd(3'b000, 1'b0, 1'b0, 4'h5, 4'h0, 4'h5, 0);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_use_acc = 1'b0;
    cmd_a = 4'h1; cmd_b = 4'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_issue_e1", {7'd0, alu_e1}, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    chk("midrst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("midrst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("midrst_acc", {4'd0, rsp_data}, 8'd0);
    chk("midrst_e1", {7'd0, alu_e1}, 8'd1);
    chk("midrst_e2_bar", {7'd0, alu_e2_bar}, 8'd0);
    chk("midrst_count", op_count, 8'd0);
    @(negedge clk);
    chk("post_rst_idle", {7'd0, rsp_valid}, 8'd0);
    send_cmd(3'b000, 1'b0, 1'b0, 4'h2, 4'h3, 4'h5, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset: clk, rst_n.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1 bit: synchronous reset, active low.
REQ-004 Port cmd_valid, input, 1 bit: the command fields are valid.
REQ-005 Port cmd_ready, output, 1 bit: the sequencer accepts a command this cycle.
REQ-006 Port cmd_op, input, 3 bits: ALU select code (000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110 NOT1, 111 NOT2).
REQ-007 Port cmd_use_acc, input, 1 bit: 1 uses the accumulator as operand A; 0 uses cmd_a.
REQ-008 Port cmd_clr, input, 1 bit: clear the accumulator to 0 instead of issuing an ALU operation.
REQ-009 Port cmd_a, input, 4 bits: operand A when cmd_use_acc=0.
REQ-010 Port cmd_b, input, 4 bits: operand B.
REQ-011 Ports alu_in1 and alu_in2, output, 4 bits each: ALU operands.
REQ-012 Port alu_sel, output, 3 bits: ALU operation select.
REQ-013 Ports alu_e1 and alu_e2_bar, output, 1 bit each: ALU enables; the ALU output is forced to 0 when e1=1 and e2_bar=0.
REQ-014 Port alu_out, input, 4 bits: combinational ALU result.
REQ-015 Port rsp_valid, output, 1 bit: the response is valid.
REQ-016 Port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-017 Port rsp_data, output, 4 bits: the result, which equals the new accumulator value.
REQ-018 Port rsp_zero, output, 1 bit: 1 when rsp_data is 0.
REQ-019 Port op_count, output, 8 bits: number of completed responses, wrapping modulo 256.

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid=1 and cmd_ready=1.
REQ-022 IDLE SHALL go to ISSUE on an accepted command with cmd_clr=0, and SHALL go directly to RESP on an accepted command with cmd_clr=1.
REQ-023 On acceptance, the sequencer SHALL register op, operand A (the accumulator or cmd_a, sampled at acceptance) and operand B.
REQ-024 In ISSUE, the sequencer SHALL drive alu_in1=A, alu_in2=B, alu_sel=op, alu_e1=0 and alu_e2_bar=1.
REQ-025 At the end of ISSUE, the accumulator SHALL load alu_out, and the FSM SHALL go to RESP.
REQ-026 Outside ISSUE, the sequencer SHALL drive alu_e1=1, alu_e2_bar=0, alu_in1=0, alu_in2=0 and alu_sel=0, so that the ALU is gated.
REQ-027 In RESP, rsp_valid SHALL be 1, with rsp_data=acc and rsp_zero=(acc==0).
REQ-028 rsp_data and rsp_zero SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-029 When RESP sees rsp_ready=1, the FSM SHALL go to IDLE and op_count SHALL increment, wrapping from 255 to 0.
REQ-030 Latency SHALL be fixed: a command accepted in cycle N has rsp_valid=1 in cycle N+2 (clear: cycle N+1).
REQ-031 The minimum command interval SHALL be 3 cycles (clear: 2 cycles), because cmd_ready is 0 in ISSUE and RESP.
REQ-032 Results SHALL be 4 bits and carries SHALL be discarded: ADD and SUB wrap modulo 16, and MUL keeps the low 4 bits of the product.
REQ-033 The sequencer SHALL capture alu_out unmodified; NOT1 and NOT2 are logical NOT (the result is 1 when the operand is 0, otherwise 0).
REQ-034 cmd_valid arriving in ISSUE or RESP SHALL be held off by cmd_ready=0, and no command SHALL be dropped or duplicated.
REQ-035 A clear command SHALL set acc=0 and SHALL produce a response with rsp_data=0 and rsp_zero=1.

Reset
REQ-036 When rst_n=0 at a rising edge, the block SHALL set: state=IDLE, acc=0, op_count=0, rsp_valid=0 and cmd_ready=1.
REQ-037 During reset the ALU drive SHALL be gated: alu_e1=1, alu_e2_bar=0, and operands and select at 0.
REQ-038 Reset asserted in ISSUE or RESP SHALL abandon the operation, produce no response and leave the accumulator unchanged by that operation.

Structure
REQ-039 Package alu_ctrl_pkg SHALL hold: the data width constant (4), the alu_op_e enum for the 3-bit codes and the seq_state_e enum.
REQ-040 The block SHALL have no sub-module; the ALU is external and connected through the alu_* ports.
REQ-041 The testbench SHALL instantiate the team ALU and connect it to the alu_* ports.

Verification
REQ-042 Scenario: reset; then {ADD, use_acc=0, a=5, b=0} -> rsp_data=5, rsp_valid at N+2, op_count=1.
REQ-043 Scenario: acc=5, {SUB, use_acc=1, b=3} -> rsp_data=2; then {SUB, use_acc=1, b=3} -> rsp_data=4'hF (wrap).
REQ-044 Scenario: {MUL, a=4, b=5} -> rsp_data=4'h4; {NOT1, a=2} -> rsp_data=0, rsp_zero=1; {NOT1, a=0} -> rsp_data=1.
REQ-045 Scenario: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, an extra cmd_valid is not accepted; release -> op_count increments once.
REQ-046 Scenario: assert rst_n=0 during ISSUE -> next cycle state=IDLE, rsp_valid=0, acc=0, alu_e1=1, alu_e2_bar=0.
REQ-047 Scenario: {clr=1} with acc=7 -> response at N+1 with rsp_data=0 and rsp_zero=1; alu_e1 stays 1 throughout.
